// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for instruction fetch
package fetch_pkg;
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DROP  = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
    localparam int          INST_BYTES_DEF   = 4;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;
endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - architectural PC register with reset vector and load enable
module pc_register #(
    parameter int            N            = 32,
    parameter logic [N-1:0]  RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);
    logic [N-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;
endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding instruction fetch sequencer with redirect
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int            N            = 32,
    parameter logic [N-1:0]  RESET_VECTOR = N'(RESET_VECTOR_DEF),
    parameter int            INST_BYTES   = INST_BYTES_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst_data,
    output logic [N-1:0] inst_pc,
    output logic         fetch_fault
);
    fetch_state_e state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic         pc_load;
    logic [31:0]  inst_data_q;
    logic [N-1:0] inst_pc_q;
    logic         redir_bad;
    logic         redir_ok;
    logic         resp_take;

    assign redir_bad = redirect_valid && ((redirect_target[1:0] & ALIGN_MASK) != 2'b00);
    assign redir_ok  = redirect_valid && !redir_bad && (state_q != ST_FAULT);
    // A response only lands in the buffer when no redirect competes for the same cycle.
    assign resp_take = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;

    always_comb begin
        pc_load = 1'b0;
        pc_d    = pc_q;
        if (redir_ok) begin
            pc_load = 1'b1;
            pc_d    = redirect_target;
        end else if (resp_take) begin
            pc_load = 1'b1;
            pc_d    = pc_q + N'(INST_BYTES);
        end
    end

    pc_register #(
        .N           (N),
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(pc_load),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else if (redir_bad) begin
            state_q <= ST_FAULT;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_REQ;
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state_q <= redirect_valid ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        state_q <= imem_resp_valid ? ST_REQ : ST_DROP;
                    end else if (imem_resp_valid) begin
                        state_q     <= ST_HOLD;
                        inst_data_q <= imem_resp_data;
                        inst_pc_q   <= pc_q;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_BOOT;
            endcase
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == ST_HOLD);
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_fault    = (state_q == ST_FAULT);
endmodule
